moldudp64_seq_tracker: RTL and testbench

MOLDUDP64_SEQ_TRACKER -- requirements
Module: moldudp64_seq_tracker

---
 rtl/moldudp64_seq_tracker.sv | 220 ++++++++++++++++++++++
 tb/tb_moldudp64_seq_tracker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_seq_tracker.sv
// MoldUDP64 sequence tracker: locks to a session, classifies packets,
// and raises retransmission requests. Option: MOLDUDP64_SESSION_CHECK_EN.
module moldudp64_seq_tracker #(
  parameter logic [15:0] MAX_GAP_REQ = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [79:0] hdr_session,
  input  logic [63:0] hdr_seq_num,
  input  logic [15:0] hdr_msg_cnt,
  output logic        pkt_accept,
  output logic        pkt_drop,
  output logic [15:0] pkt_skip,
  output logic [63:0] expected_seq,
  output logic        gap_valid,
  input  logic        gap_ready,
  output logic [63:0] gap_seq,
  output logic [15:0] gap_cnt,
  output logic        session_end,
  output logic [31:0] stat_gap,
  output logic [31:0] stat_dup
);

  typedef enum logic [1:0] {
    S_UNLOCKED,
    S_TRACK,
    S_GAP_REQ,
    S_ENDED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [79:0] r_session;
  logic [63:0] r_exp;
  logic        r_accept;
  logic        r_drop;
  logic [15:0] r_skip;
  logic        r_send;
  logic        r_gap_valid;
  logic [63:0] r_gap_seq;
  logic [15:0] r_gap_cnt;
  logic [31:0] r_stat_gap;
  logic [31:0] r_stat_dup;

  logic [79:0] w_session_nxt;
  logic [63:0] w_exp_nxt;
  logic        w_accept_nxt;
  logic        w_drop_nxt;
  logic [15:0] w_skip_nxt;
  logic        w_send_nxt;
  logic        w_gap_valid_nxt;
  logic [63:0] w_gap_seq_nxt;
  logic [15:0] w_gap_cnt_nxt;
  logic        w_gap_inc;
  logic        w_dup_inc;
  logic        w_lock;

  logic        w_take;
  logic        w_cnt_zero;
  logic        w_cnt_end;
  logic        w_cnt_data;
  logic [63:0] w_seq_end;
  logic [63:0] w_diff;
  logic [15:0] w_gap_clamped;
  logic [15:0] w_skip;
  logic        w_seq_eq;
  logic        w_seq_gt;
  logic        w_sess_match;
  logic        w_track_ok;
  logic        w_relock;

  assign hdr_ready    = (r_state != S_GAP_REQ);
  assign w_take       = hdr_valid & hdr_ready;

  assign w_cnt_zero   = (hdr_msg_cnt == 16'h0000);
  assign w_cnt_end    = (hdr_msg_cnt == 16'hFFFF);
  assign w_cnt_data   = ~w_cnt_zero & ~w_cnt_end;

  assign w_seq_end    = hdr_seq_num + {48'd0, hdr_msg_cnt};
  assign w_diff       = hdr_seq_num - r_exp;
  assign w_gap_clamped = (w_diff > {48'd0, MAX_GAP_REQ}) ?
                         MAX_GAP_REQ : w_diff[15:0];
  // Overlap is always shorter than the packet, so 16 bits suffice.
  assign w_skip       = r_exp[15:0] - hdr_seq_num[15:0];
  assign w_seq_eq     = (hdr_seq_num == r_exp);
  assign w_seq_gt     = (hdr_seq_num > r_exp);
  assign w_sess_match = (hdr_session == r_session);

`ifdef MOLDUDP64_SESSION_CHECK_EN
  assign w_track_ok = w_sess_match;
  assign w_relock   = ~w_sess_match;
`else
  logic w_unused_sess;
  assign w_unused_sess = w_sess_match;
  assign w_track_ok = 1'b1;
  assign w_relock   = 1'b1;
`endif

  assign pkt_accept   = r_accept;
  assign pkt_drop     = r_drop;
  assign pkt_skip     = r_skip;
  assign expected_seq = r_exp;
  assign gap_valid    = r_gap_valid;
  assign gap_seq      = r_gap_seq;
  assign gap_cnt      = r_gap_cnt;
  assign session_end  = r_send;
  assign stat_gap     = r_stat_gap;
  assign stat_dup     = r_stat_dup;

  // Next-state and next-output decision for the accepted header.
  always_comb begin
    w_state_nxt     = r_state;
    w_session_nxt   = r_session;
    w_exp_nxt       = r_exp;
    w_accept_nxt    = 1'b0;
    w_drop_nxt      = 1'b0;
    w_skip_nxt      = 16'd0;
    w_send_nxt      = 1'b0;
    w_gap_valid_nxt = r_gap_valid;
    w_gap_seq_nxt   = r_gap_seq;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_gap_inc       = 1'b0;
    w_dup_inc       = 1'b0;
    w_lock          = 1'b0;

    unique case (r_state)
      S_UNLOCKED: begin
        if (w_take) w_lock = 1'b1;
      end
      S_TRACK: begin
        if (w_take) begin
          if (!w_track_ok) begin
            w_drop_nxt = 1'b1;
          end else if (w_seq_eq) begin
            if (w_cnt_data) begin
              w_accept_nxt = 1'b1;
              w_exp_nxt    = w_seq_end;
            end else if (w_cnt_end) begin
              w_send_nxt  = 1'b1;
              w_state_nxt = S_ENDED;
            end
          end else if (w_seq_gt) begin
            w_drop_nxt      = 1'b1;
            w_gap_inc       = 1'b1;
            w_gap_valid_nxt = 1'b1;
            w_gap_seq_nxt   = r_exp;
            w_gap_cnt_nxt   = w_gap_clamped;
            w_state_nxt     = S_GAP_REQ;
          end else if (w_seq_end <= r_exp) begin
            if (!w_cnt_zero) begin
              w_drop_nxt = 1'b1;
              w_dup_inc  = 1'b1;
            end
          end else begin
            w_accept_nxt = 1'b1;
            w_skip_nxt   = w_skip;
            w_exp_nxt    = w_seq_end;
          end
        end
      end
      S_GAP_REQ: begin
        if (gap_ready) begin
          w_gap_valid_nxt = 1'b0;
          w_state_nxt     = S_TRACK;
        end
      end
      S_ENDED: begin
        if (w_take) begin
          if (w_relock) w_lock = 1'b1;
          else          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_UNLOCKED;
    endcase

    if (w_lock) begin
      w_session_nxt = hdr_session;
      w_state_nxt   = w_cnt_end ? S_ENDED : S_TRACK;
      w_exp_nxt     = w_cnt_data ? w_seq_end : hdr_seq_num;
      w_accept_nxt  = w_cnt_data;
    end
  end

  // State, decision outputs and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_UNLOCKED;
      r_session   <= '0;
      r_exp       <= '0;
      r_accept    <= 1'b0;
      r_drop      <= 1'b0;
      r_skip      <= '0;
      r_send      <= 1'b0;
      r_gap_valid <= 1'b0;
      r_gap_seq   <= '0;
      r_gap_cnt   <= '0;
      r_stat_gap  <= '0;
      r_stat_dup  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_session   <= w_session_nxt;
      r_exp       <= w_exp_nxt;
      r_accept    <= w_accept_nxt;
      r_drop      <= w_drop_nxt;
      r_skip      <= w_skip_nxt;
      r_send      <= w_send_nxt;
      r_gap_valid <= w_gap_valid_nxt;
      r_gap_seq   <= w_gap_seq_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      if (w_gap_inc && r_stat_gap != 32'hFFFF_FFFF)
        r_stat_gap <= r_stat_gap + 32'd1;
      if (w_dup_inc && r_stat_dup != 32'hFFFF_FFFF)
        r_stat_dup <= r_stat_dup + 32'd1;
    end
  end

endmodule

// File: tb/tb_moldudp64_seq_tracker.sv
// Scoreboard bench for moldudp64_seq_tracker.
// Expected per-header decisions are queued and checked one cycle later.
module tb_moldudp64_seq_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [79:0] hdr_session = '0;
  logic [63:0] hdr_seq_num = '0;
  logic [15:0] hdr_msg_cnt = '0;
  logic        pkt_accept;
  logic        pkt_drop;
  logic [15:0] pkt_skip;
  logic [63:0] expected_seq;
  logic        gap_valid;
  logic        gap_ready = 1'b0;
  logic [63:0] gap_seq;
  logic [15:0] gap_cnt;
  logic        session_end;
  logic [31:0] stat_gap;
  logic [31:0] stat_dup;

  localparam logic [79:0] S1 = 80'h1234_5678_9ABC;
  localparam logic [79:0] S2 = 80'hABCD_EF01;

  typedef struct packed {
    logic        acc;
    logic        drp;
    logic        send;
    logic [15:0] skip;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  moldudp64_seq_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_session(hdr_session), .hdr_seq_num(hdr_seq_num),
    .hdr_msg_cnt(hdr_msg_cnt),
    .pkt_accept(pkt_accept), .pkt_drop(pkt_drop),
    .pkt_skip(pkt_skip), .expected_seq(expected_seq),
    .gap_valid(gap_valid), .gap_ready(gap_ready),
    .gap_seq(gap_seq), .gap_cnt(gap_cnt),
    .session_end(session_end),
    .stat_gap(stat_gap), .stat_dup(stat_dup)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: compare decisions one cycle after each accepted header.
  exp_t e;
  always @(posedge clk) begin
    if (rst_n && hdr_valid && hdr_ready) begin
      #1;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: header accepted with no expectation");
      end else begin
        e = sb.pop_front();
        n_total += 4;
        if (pkt_accept !== e.acc)
          $display("FAIL accept: got %b want %b", pkt_accept, e.acc);
        else n_pass++;
        if (pkt_drop !== e.drp)
          $display("FAIL drop: got %b want %b", pkt_drop, e.drp);
        else n_pass++;
        if (session_end !== e.send)
          $display("FAIL session_end: got %b want %b", session_end, e.send);
        else n_pass++;
        if (expected_seq !== e.exp)
          $display("FAIL expected_seq: got %h want %h", expected_seq, e.exp);
        else n_pass++;
        if (e.acc) begin
          n_total++;
          if (pkt_skip !== e.skip)
            $display("FAIL skip: got %0d want %0d", pkt_skip, e.skip);
          else n_pass++;
        end
      end
    end
  end

  task automatic hdr(input logic [79:0] s, input logic [63:0] q,
                     input logic [15:0] c, input logic a, input logic d,
                     input logic en, input logic [15:0] k,
                     input logic [63:0] x);
    exp_t t;
    t.acc = a; t.drp = d; t.send = en; t.skip = k; t.exp = x;
    sb.push_back(t);
    @(negedge clk);
    hdr_valid = 1'b1; hdr_session = s;
    hdr_seq_num = q; hdr_msg_cnt = c;
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic release_gap();
    @(negedge clk); gap_ready = 1'b1;
    @(negedge clk); gap_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total += 5;
    if (hdr_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", hdr_ready);
    else n_pass++;
    if (gap_valid !== 1'b0) $display("FAIL rst_gap: got %b want 0", gap_valid);
    else n_pass++;
    if ({pkt_accept, pkt_drop, session_end} !== 3'b000)
      $display("FAIL rst_pulses: got %b want 000", {pkt_accept, pkt_drop, session_end});
    else n_pass++;
    if (expected_seq !== 64'd0) $display("FAIL rst_exp: got %h want 0", expected_seq);
    else n_pass++;
    if ({stat_gap, stat_dup} !== 64'd0)
      $display("FAIL rst_stats: got %h want 0", {stat_gap, stat_dup});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_in_order();
    hdr(S1, 64'd1, 16'd3, 1, 0, 0, 16'd0, 64'd4);
    hdr(S1, 64'd4, 16'd2, 1, 0, 0, 16'd0, 64'd6);
    hdr(S1, 64'd6, 16'd0, 0, 0, 0, 16'd0, 64'd6);
  endtask

  task automatic test_gap();
    hdr(S1, 64'd20, 16'd1, 0, 1, 0, 16'd0, 64'd6);
    n_total += 3;
    if (gap_seq !== 64'd6) $display("FAIL gap_seq: got %0d want 6", gap_seq);
    else n_pass++;
    if (gap_cnt !== 16'd14) $display("FAIL gap_cnt: got %0d want 14", gap_cnt);
    else n_pass++;
    if (stat_gap !== 32'd1) $display("FAIL stat_gap: got %0d want 1", stat_gap);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (hdr_ready !== 1'b0 || gap_valid !== 1'b1 || gap_seq !== 64'd6 || gap_cnt !== 16'd14)
        $display("FAIL gap_hold%0d: ready=%b valid=%b seq=%0d cnt=%0d want 0 1 6 14",
                 i, hdr_ready, gap_valid, gap_seq, gap_cnt);
      else n_pass++;
      @(negedge clk);
    end
    release_gap();
    n_total++;
    if (gap_valid !== 1'b0 || hdr_ready !== 1'b1)
      $display("FAIL gap_release: valid=%b ready=%b want 0 1", gap_valid, hdr_ready);
    else n_pass++;
  endtask

  task automatic test_overlap_dup();
    hdr(S1, 64'd6, 16'd4, 1, 0, 0, 16'd0, 64'd10);
    hdr(S1, 64'd8, 16'd5, 1, 0, 0, 16'd2, 64'd13);
    hdr(S1, 64'd9, 16'd2, 0, 1, 0, 16'd0, 64'd13);
    hdr(S1, 64'd5, 16'd0, 0, 0, 0, 16'd0, 64'd13);
    n_total++;
    if (stat_dup !== 32'd1) $display("FAIL stat_dup: got %0d want 1", stat_dup);
    else n_pass++;
  endtask

  task automatic test_clamp_wrap();
    do_reset();
    hdr(S1, 64'd0, 16'd0, 0, 0, 0, 16'd0, 64'd0);
    hdr(S1, 64'd70000, 16'd1, 0, 1, 0, 16'd0, 64'd0);
    n_total += 2;
    if (gap_cnt !== 16'd1000) $display("FAIL clamp_cnt: got %0d want 1000", gap_cnt);
    else n_pass++;
    if (gap_seq !== 64'd0) $display("FAIL clamp_seq: got %0d want 0", gap_seq);
    else n_pass++;
    release_gap();
    do_reset();
    hdr(S1, 64'hFFFF_FFFF_FFFF_FFFE, 16'd0, 0, 0, 0, 16'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    hdr(S1, 64'hFFFF_FFFF_FFFF_FFFE, 16'd3, 1, 0, 0, 16'd0, 64'd1);
  endtask

  task automatic test_async_reset();
    hdr(S1, 64'd50, 16'd1, 0, 1, 0, 16'd0, 64'd1);
    n_total++;
    if (gap_valid !== 1'b1) $display("FAIL pre_rst_gap: got %b want 1", gap_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (gap_valid !== 1'b0 || hdr_ready !== 1'b1)
      $display("FAIL async_rst: valid=%b ready=%b want 0 1", gap_valid, hdr_ready);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (gap_valid !== 1'b0 || expected_seq !== 64'd0)
      $display("FAIL post_rst: valid=%b exp=%0d want 0 0", gap_valid, expected_seq);
    else n_pass++;
    hdr(S1, 64'd100, 16'd2, 1, 0, 0, 16'd0, 64'd102);
  endtask

  task automatic test_end_relock();
    hdr(S1, 64'd102, 16'hFFFF, 0, 0, 1, 16'd0, 64'd102);
`ifdef MOLDUDP64_SESSION_CHECK_EN
    hdr(S1, 64'd200, 16'd5, 0, 1, 0, 16'd0, 64'd102);
    hdr(S2, 64'd200, 16'd5, 1, 0, 0, 16'd0, 64'd205);
    hdr(S1, 64'd205, 16'd1, 0, 1, 0, 16'd0, 64'd205);
`else
    hdr(S1, 64'd200, 16'd5, 1, 0, 0, 16'd0, 64'd205);
    hdr(S2, 64'd205, 16'd1, 1, 0, 0, 16'd0, 64'd206);
`endif
    do_reset();
    hdr(S2, 64'd7, 16'hFFFF, 0, 0, 0, 16'd0, 64'd7);
    hdr(S1, 64'd30, 16'd1, 1, 0, 0, 16'd0, 64'd31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_in_order();
    test_gap();
    test_overlap_dup();
    test_clamp_wrap();
    test_async_reset();
    test_end_relock();
    repeat (3) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_left: got %0d want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
